cdr_lock_ctrl: RTL and testbench

Lock-acquisition sequencer for the CDR loop. It watches the bang-bang phase detector's Up/Dn votes over fixed windows and selects the digital loop filter gain (acquisition or tracking). It also declares lock or loss-of-lock and can hold the loop filter on request. It sits beside the phase detector and loop filter in the CDR, clocked by the same reference clock as the loop filter.

---
 rtl/cdr_ctrl_pkg.sv | 32 +++
 rtl/cdr_win_stats.sv | 72 +++++++
 rtl/cdr_lock_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cdr_lock_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cdr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdr_ctrl_pkg
// Description : Shared state encoding and default constants for the CDR lock
//               acquisition sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cdr_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACQ    = 3'd1,
      ST_VERIFY = 3'd2,
      ST_LOCKED = 3'd3,
      ST_HOLD   = 3'd4
   } cdr_state_e;

   localparam int unsigned c_def_win_w           = 8;
   localparam int unsigned c_def_acq_windows     = 8;
   localparam int unsigned c_def_good_windows    = 4;
   localparam int unsigned c_def_timeout_windows = 64;
   localparam int unsigned c_def_lock_thr        = 16;
   localparam int unsigned c_def_unlock_thr      = 48;
   localparam int unsigned c_def_min_act         = 32;

   // Width of a counter indexing 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdr_win_stats.sv
`default_nettype none
// ============================================================================
// Module      : cdr_win_stats
// Description : Fixed-length Up/Dn vote window with good/bad classification.
// Revision    : 1.0 - initial release
// ============================================================================
module cdr_win_stats
   import cdr_ctrl_pkg::*;
#(
   parameter int unsigned WIN_W      = c_def_win_w,
   parameter int unsigned LOCK_THR   = c_def_lock_thr,
   parameter int unsigned UNLOCK_THR = c_def_unlock_thr,
   parameter int unsigned MIN_ACT    = c_def_min_act
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic up_i,
   input  logic dn_i,
   output logic win_done_o,
   output logic win_good_o,
   output logic win_bad_o
);

   localparam logic [WIN_W:0] c_lock_thr   = (WIN_W+1)'(LOCK_THR);
   localparam logic [WIN_W:0] c_unlock_thr = (WIN_W+1)'(UNLOCK_THR);
   localparam logic [WIN_W:0] c_min_act    = (WIN_W+1)'(MIN_ACT);

   logic [WIN_W-1:0] win_cnt_q;
   logic [WIN_W:0]   up_cnt_q;
   logic [WIN_W:0]   dn_cnt_q;
   logic             w_up_vote;
   logic             w_dn_vote;
   logic [WIN_W:0]   w_up_tot;
   logic [WIN_W:0]   w_dn_tot;
   logic [WIN_W:0]   w_imb;
   logic [WIN_W:0]   w_act;

   // Simultaneous Up and Dn carry no phase information and count as neither.
   assign w_up_vote = up_i & ~dn_i;
   assign w_dn_vote = dn_i & ~up_i;

   // Totals include the current vote so the last cycle of a window is scored.
   assign w_up_tot = up_cnt_q + {{WIN_W{1'b0}}, w_up_vote};
   assign w_dn_tot = dn_cnt_q + {{WIN_W{1'b0}}, w_dn_vote};
   assign w_imb    = (w_up_tot >= w_dn_tot) ? (w_up_tot - w_dn_tot)
                                            : (w_dn_tot - w_up_tot);
   assign w_act    = w_up_tot + w_dn_tot;

   assign win_done_o = &win_cnt_q;
   assign win_good_o = win_done_o && (w_imb <= c_lock_thr) && (w_act >= c_min_act);
   assign win_bad_o  = win_done_o && ((w_imb > c_unlock_thr) || (w_act < c_min_act));

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         win_cnt_q <= '0;
         up_cnt_q  <= '0;
         dn_cnt_q  <= '0;
      end else begin
         win_cnt_q <= win_cnt_q + WIN_W'(1);
         if (win_done_o) begin
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
         end else begin
            up_cnt_q <= w_up_tot;
            dn_cnt_q <= w_dn_tot;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cdr_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cdr_lock_ctrl
// Description : CDR lock-acquisition sequencer: gain select, lock detect and
//               loop-filter hold control driven by windowed Up/Dn statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module cdr_lock_ctrl
   import cdr_ctrl_pkg::*;
#(
   parameter int unsigned WIN_W           = c_def_win_w,
   parameter int unsigned ACQ_WINDOWS     = c_def_acq_windows,
   parameter int unsigned GOOD_WINDOWS    = c_def_good_windows,
   parameter int unsigned TIMEOUT_WINDOWS = c_def_timeout_windows,
   parameter int unsigned LOCK_THR        = c_def_lock_thr,
   parameter int unsigned UNLOCK_THR      = c_def_unlock_thr,
   parameter int unsigned MIN_ACT         = c_def_min_act
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up,
   input  logic       dn,
   input  logic       freeze_req,
   output logic       gain_hi,
   output logic       dlf_hold,
   output logic       locked,
   output logic       lock_lost,
   output logic       acq_timeout,
   output logic [2:0] state
);

   localparam int unsigned c_acq_w  = cnt_width(ACQ_WINDOWS);
   localparam int unsigned c_ver_w  = cnt_width(TIMEOUT_WINDOWS);
   localparam int unsigned c_good_w = cnt_width(GOOD_WINDOWS);

   localparam logic [c_acq_w-1:0]  c_acq_last  = c_acq_w'(ACQ_WINDOWS - 1);
   localparam logic [c_ver_w-1:0]  c_ver_last  = c_ver_w'(TIMEOUT_WINDOWS - 1);
   localparam logic [c_good_w-1:0] c_good_last = c_good_w'(GOOD_WINDOWS - 1);

   cdr_state_e          state_q, state_d;
   logic [c_acq_w-1:0]  acq_cnt_q, acq_cnt_d;
   logic [c_ver_w-1:0]  ver_cnt_q, ver_cnt_d;
   logic [c_good_w-1:0] good_cnt_q, good_cnt_d;
   logic                lost_d;
   logic                timeout_d;
   logic                gain_hi_q;
   logic                dlf_hold_q;
   logic                locked_q;
   logic                lock_lost_q;
   logic                acq_timeout_q;
   logic                win_done;
   logic                win_good;
   logic                win_bad;
   logic                stats_clr;

   // Window restarts on every state change and stays idle while not observing.
   assign stats_clr = (state_d != state_q) || (state_q == ST_IDLE) ||
                      (state_q == ST_HOLD);

   cdr_win_stats #(
      .WIN_W      (WIN_W),
      .LOCK_THR   (LOCK_THR),
      .UNLOCK_THR (UNLOCK_THR),
      .MIN_ACT    (MIN_ACT)
   ) u_win_stats (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (stats_clr),
      .up_i       (up),
      .dn_i       (dn),
      .win_done_o (win_done),
      .win_good_o (win_good),
      .win_bad_o  (win_bad)
   );

   always_comb begin
      state_d    = state_q;
      acq_cnt_d  = acq_cnt_q;
      ver_cnt_d  = ver_cnt_q;
      good_cnt_d = good_cnt_q;
      lost_d     = 1'b0;
      timeout_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_ACQ;
         end
         ST_ACQ: begin
            if (win_done) begin
               if (acq_cnt_q == c_acq_last) state_d = ST_VERIFY;
               else acq_cnt_d = acq_cnt_q + c_acq_w'(1);
            end
         end
         ST_VERIFY: begin
            if (win_done) begin
               ver_cnt_d  = ver_cnt_q + c_ver_w'(1);
               good_cnt_d = win_good ? (good_cnt_q + c_good_w'(1)) : '0;
               // Reaching lock on the final allowed window beats the timeout.
               if (win_good && (good_cnt_q == c_good_last)) begin
                  state_d = ST_LOCKED;
               end else if (ver_cnt_q == c_ver_last) begin
                  state_d   = ST_ACQ;
                  timeout_d = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (freeze_req) begin
               state_d = ST_HOLD;
            end else if (win_bad) begin
               state_d = ST_ACQ;
               lost_d  = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!freeze_req) state_d = ST_LOCKED;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!en) begin
         state_d   = ST_IDLE;
         lost_d    = 1'b0;
         timeout_d = 1'b0;
      end

      if ((state_d == ST_ACQ) && (state_q != ST_ACQ)) begin
         acq_cnt_d  = '0;
         ver_cnt_d  = '0;
         good_cnt_d = '0;
      end
   end

   // Outputs are decoded from the next state so they change with the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         acq_cnt_q     <= '0;
         ver_cnt_q     <= '0;
         good_cnt_q    <= '0;
         gain_hi_q     <= 1'b0;
         dlf_hold_q    <= 1'b1;
         locked_q      <= 1'b0;
         lock_lost_q   <= 1'b0;
         acq_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         acq_cnt_q     <= acq_cnt_d;
         ver_cnt_q     <= ver_cnt_d;
         good_cnt_q    <= good_cnt_d;
         gain_hi_q     <= (state_d == ST_ACQ);
         dlf_hold_q    <= (state_d == ST_IDLE) || (state_d == ST_HOLD);
         locked_q      <= (state_d == ST_LOCKED) || (state_d == ST_HOLD);
         lock_lost_q   <= lost_d;
         acq_timeout_q <= timeout_d;
      end
   end

   assign gain_hi     = gain_hi_q;
   assign dlf_hold    = dlf_hold_q;
   assign locked      = locked_q;
   assign lock_lost   = lock_lost_q;
   assign acq_timeout = acq_timeout_q;
   assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cdr_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdr_lock_ctrl
// Description : Directed scoreboard bench for the CDR lock sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdr_lock_ctrl;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACQ    = 3'd1;
   localparam logic [2:0] S_VERIFY = 3'd2;
   localparam logic [2:0] S_LOCKED = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   localparam int P_ALT  = 0;
   localparam int P_UP   = 1;
   localparam int P_BOTH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       dn = 1'b0;
   logic       freeze_req = 1'b0;
   logic       gain_hi, dlf_hold, locked, lock_lost, acq_timeout;
   logic [2:0] state;

   typedef struct {
      int         cyc;
      string      tag;
      logic [7:0] vec;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cdr_lock_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .up          (up),
      .dn          (dn),
      .freeze_req  (freeze_req),
      .gain_hi     (gain_hi),
      .dlf_hold    (dlf_hold),
      .locked      (locked),
      .lock_lost   (lock_lost),
      .acq_timeout (acq_timeout),
      .state       (state)
   );

   // Expected {state, gain_hi, dlf_hold, locked, lock_lost, acq_timeout}.
   function automatic logic [7:0] ev(input logic [2:0] st, input logic lost, input logic to);
      logic [2:0] m;
      case (st)
         S_IDLE:   m = 3'b010;
         S_ACQ:    m = 3'b100;
         S_VERIFY: m = 3'b000;
         S_LOCKED: m = 3'b001;
         S_HOLD:   m = 3'b011;
         default:  m = 3'bxxx;
      endcase
      return {st, m, lost, to};
   endfunction

   task automatic push(input int c, input string tag, input logic [2:0] st,
                       input logic lost, input logic to);
      exp_t e;
      e.cyc = c;
      e.tag = tag;
      e.vec = ev(st, lost, to);
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t       e;
      logic [7:0] obs;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e   = sb.pop_front();
         obs = {state, gain_hi, dlf_hold, locked, lock_lost, acq_timeout};
         checks++;
         assert (obs === e.vec) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", e.tag, cyc, obs, e.vec);
         end
      end
   endtask

   task automatic drive(input int pat);
      case (pat)
         P_ALT:   begin up = (cyc % 2 == 0); dn = (cyc % 2 != 0); end
         P_UP:    begin up = 1'b1; dn = 1'b0; end
         default: begin up = 1'b1; dn = 1'b1; end
      endcase
   endtask

   task automatic run_to(input int last, input int pat);
      while (cyc <= last) begin
         drive(pat);
         step();
      end
   endtask

   initial begin
      // Reset asserted with en high must still give IDLE outputs.
      rst_n = 1'b0;
      en    = 1'b1;
      push(1, "reset_vals", S_IDLE, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      en    = 1'b0;
      push(2, "idle_no_en", S_IDLE, 1'b0, 1'b0);
      step();

      // Scenario 1: acquisition to lock with balanced votes.
      cyc = 0;
      en  = 1'b1;
      push(1,    "acq_entry",    S_ACQ,    1'b0, 1'b0);
      push(2048, "acq_last",     S_ACQ,    1'b0, 1'b0);
      push(2049, "verify_entry", S_VERIFY, 1'b0, 1'b0);
      push(3072, "verify_last",  S_VERIFY, 1'b0, 1'b0);
      push(3073, "lock_entry",   S_LOCKED, 1'b0, 1'b0);
      push(3328, "locked_hold",  S_LOCKED, 1'b0, 1'b0);
      run_to(3328, P_ALT);

      // Scenario 3: one full up-only window while locked.
      push(3584, "bad_win_last", S_LOCKED, 1'b0, 1'b0);
      push(3585, "lock_lost",    S_ACQ,    1'b1, 1'b0);
      push(3586, "lost_one_cyc", S_ACQ,    1'b0, 1'b0);
      run_to(3585, P_UP);

      // Scenario 2: constant Up never locks and times out.
      push(5632,  "reacq_last",    S_ACQ,    1'b0, 1'b0);
      push(5633,  "reverify",      S_VERIFY, 1'b0, 1'b0);
      push(22016, "verify_no_lock", S_VERIFY, 1'b0, 1'b0);
      push(22017, "acq_timeout",   S_ACQ,    1'b0, 1'b1);
      push(22018, "timeout_1cyc",  S_ACQ,    1'b0, 1'b0);
      run_to(22017, P_UP);

      // Scenario 4: up=dn=1 gives zero activity.
      push(24064, "both_acq_last", S_ACQ,    1'b0, 1'b0);
      push(24065, "both_verify",   S_VERIFY, 1'b0, 1'b0);
      push(25089, "both_no_lock",  S_VERIFY, 1'b0, 1'b0);
      push(40448, "both_last_win", S_VERIFY, 1'b0, 1'b0);
      push(40449, "both_timeout",  S_ACQ,    1'b0, 1'b1);
      run_to(40448, P_BOTH);

      // Scenario 5: freeze while locked with Up stuck.
      push(42497, "s5_verify",   S_VERIFY, 1'b0, 1'b0);
      push(43520, "s5_ver_last", S_VERIFY, 1'b0, 1'b0);
      push(43521, "s5_locked",   S_LOCKED, 1'b0, 1'b0);
      push(43600, "pre_freeze",  S_LOCKED, 1'b0, 1'b0);
      run_to(43599, P_ALT);
      push(43601, "hold_entry",   S_HOLD,   1'b0, 1'b0);
      push(44000, "hold_mid",     S_HOLD,   1'b0, 1'b0);
      push(44600, "hold_last",    S_HOLD,   1'b0, 1'b0);
      push(44601, "unfreeze",     S_LOCKED, 1'b0, 1'b0);
      push(44856, "fresh_win",    S_LOCKED, 1'b0, 1'b0);
      push(44857, "post_hold_lost", S_ACQ,  1'b1, 1'b0);
      while (cyc <= 44856) begin
         drive(P_UP);
         freeze_req = (cyc <= 44599);
         step();
      end
      freeze_req = 1'b0;

      // Scenario 6a: en dropped mid-VERIFY.
      push(46904, "s6_acq_last", S_ACQ,    1'b0, 1'b0);
      push(46905, "s6_verify",   S_VERIFY, 1'b0, 1'b0);
      push(47000, "pre_disable", S_VERIFY, 1'b0, 1'b0);
      push(47001, "disable",     S_IDLE,   1'b0, 1'b0);
      run_to(46999, P_ALT);
      drive(P_ALT);
      en = 1'b0;
      step();

      // Scenario 6b: reset asserted mid-LOCKED.
      en = 1'b1;
      push(49050, "s6_reverify", S_VERIFY, 1'b0, 1'b0);
      push(50074, "s6_relock",   S_LOCKED, 1'b0, 1'b0);
      push(50100, "pre_reset",   S_LOCKED, 1'b0, 1'b0);
      push(50101, "mid_reset",   S_IDLE,   1'b0, 1'b0);
      push(50102, "post_reset",  S_ACQ,    1'b0, 1'b0);
      run_to(50099, P_ALT);
      drive(P_ALT);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
